// File: rtl/pmu_io_pkg.sv
// Shared PMU GPIO bit map and FSM state encodings for the power sequencer.
package pmu_io_pkg;

  localparam int GPO_KILL_REQ = 0;
  localparam int GPO_PWR_ACK  = 1;

  localparam int GPI_PWR_REQ    = 0;
  localparam int GPI_KILL_CNT   = 1;
  localparam int GPI_KILL_ABORT = 2;
  localparam int GPI_PWR_LVL    = 3;
  localparam int GPI_KILL_DONE  = 4;

  typedef logic [1:0] btn_state_t;
  localparam btn_state_t B_IDLE = 2'd0;
  localparam btn_state_t B_REQ  = 2'd1;
  localparam btn_state_t B_ACK  = 2'd2;

  typedef logic [1:0] kill_state_t;
  localparam kill_state_t K_IDLE  = 2'd0;
  localparam kill_state_t K_COUNT = 2'd1;
  localparam kill_state_t K_KILL  = 2'd2;

endpackage

// File: rtl/pmu_io_debounce.sv
// Two-flop synchroniser followed by a stability counter; o_db follows the
// synchronised input only after it has differed for DEBOUNCE_CYCLES cycles.
module pmu_io_debounce #(
  parameter int DEBOUNCE_CYCLES = 3000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      // Any return to the current level restarts the stability window.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/pmu_power_sequencer.sv
// Power-button request/acknowledge handshake and delayed, terminal power-kill
// between the PS PMU GPIO and the board power-control pins.
module pmu_power_sequencer
  import pmu_io_pkg::*;
#(
  parameter int CLOCK_FREQUENCE = 300000000,
  parameter int DEBOUNCE_CYCLES = 3000000,
  parameter int POWERKILL_DELAY = 300000000
) (
  input  logic        CLOCK,
  input  logic        RESETN,
  input  logic [31:0] PMU_GPO,
  output logic [31:0] PMU_GPI,
  input  logic        POWER_INT,
  output logic        KILL_POWER
);

  localparam int KW = $clog2(POWERKILL_DELAY + 1);
  localparam logic [KW-1:0] K_LAST = KW'(POWERKILL_DELAY - 1);

  generate
    if (CLOCK_FREQUENCE < 1 || DEBOUNCE_CYCLES < 1 || POWERKILL_DELAY < 1) begin : g_param_check
      $error("pmu_power_sequencer: CLOCK_FREQUENCE, DEBOUNCE_CYCLES and POWERKILL_DELAY must be >= 1");
    end
  endgenerate

  logic w_db;
  logic w_db_rise;
  logic w_kill_req;
  logic w_pwr_ack;
  logic w_unused_gpo;

  btn_state_t  r_btn_state;
  logic        r_db_prev;
  logic        r_pwr_req;

  kill_state_t r_kill_state;
  logic [KW-1:0] r_kill_cnt;
  logic        r_kill_counting;
  logic        r_kill_abort;
  logic        r_kill;

  assign w_kill_req   = PMU_GPO[GPO_KILL_REQ];
  assign w_pwr_ack    = PMU_GPO[GPO_PWR_ACK];
  assign w_unused_gpo = &{1'b0, PMU_GPO[31:2]};

  pmu_io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk  (CLOCK),
    .i_rst_n(RESETN),
    .i_async(POWER_INT),
    .o_db   (w_db)
  );

  assign w_db_rise = w_db & ~r_db_prev;

  // Edges seen outside B_IDLE are dropped, so a held button yields one request.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_btn_state <= B_IDLE;
      r_db_prev   <= 1'b0;
      r_pwr_req   <= 1'b0;
    end else begin
      r_db_prev <= w_db;
      case (r_btn_state)
        B_IDLE: begin
          if (w_db_rise) begin
            r_btn_state <= B_REQ;
            r_pwr_req   <= 1'b1;
          end
        end
        B_REQ: begin
          if (w_pwr_ack) begin
            r_btn_state <= B_ACK;
            r_pwr_req   <= 1'b0;
          end
        end
        B_ACK: begin
          if (!w_pwr_ack) begin
            r_btn_state <= B_IDLE;
          end
        end
        default: begin
          r_btn_state <= B_IDLE;
          r_pwr_req   <= 1'b0;
        end
      endcase
    end
  end

  // K_KILL has no exit other than reset; the counter stops at its terminal value.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      r_kill_state    <= K_IDLE;
      r_kill_cnt      <= '0;
      r_kill_counting <= 1'b0;
      r_kill_abort    <= 1'b0;
      r_kill          <= 1'b0;
    end else begin
      case (r_kill_state)
        K_IDLE: begin
          if (w_kill_req) begin
            r_kill_state    <= K_COUNT;
            r_kill_cnt      <= '0;
            r_kill_abort    <= 1'b0;
            r_kill_counting <= 1'b1;
          end
        end
        K_COUNT: begin
          if (!w_kill_req) begin
            r_kill_state    <= K_IDLE;
            r_kill_abort    <= 1'b1;
            r_kill_counting <= 1'b0;
          end else if (r_kill_cnt == K_LAST) begin
            r_kill_state    <= K_KILL;
            r_kill          <= 1'b1;
            r_kill_counting <= 1'b0;
          end else begin
            r_kill_cnt <= r_kill_cnt + 1'b1;
          end
        end
        K_KILL: begin
          r_kill <= 1'b1;
        end
        default: begin
          r_kill_state    <= K_IDLE;
          r_kill_counting <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    PMU_GPI                 = '0;
    PMU_GPI[GPI_PWR_REQ]    = r_pwr_req;
    PMU_GPI[GPI_KILL_CNT]   = r_kill_counting;
    PMU_GPI[GPI_KILL_ABORT] = r_kill_abort;
    PMU_GPI[GPI_PWR_LVL]    = w_db;
    PMU_GPI[GPI_KILL_DONE]  = r_kill;
  end

  assign KILL_POWER = r_kill;

endmodule

// File: tb/tb_pmu_power_sequencer.sv
// Self-checking bench for pmu_power_sequencer: vector table, directed kill/reset
// sequences and a randomized run against a run-length reference model.
module tb_pmu_power_sequencer;

  localparam int DEB   = 4;
  localparam int DELAY = 10;

  logic        CLOCK = 1'b0;
  logic        RESETN;
  logic [31:0] PMU_GPO;
  logic [31:0] PMU_GPI;
  logic        POWER_INT;
  logic        KILL_POWER;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLOCK = ~CLOCK;

  pmu_power_sequencer #(
    .CLOCK_FREQUENCE(100000000),
    .DEBOUNCE_CYCLES(DEB),
    .POWERKILL_DELAY(DELAY)
  ) dut (
    .CLOCK     (CLOCK),
    .RESETN    (RESETN),
    .PMU_GPO   (PMU_GPO),
    .PMU_GPI   (PMU_GPI),
    .POWER_INT (POWER_INT),
    .KILL_POWER(KILL_POWER)
  );

  // Reference model: pin history, run lengths and simple flags.
  logic m_pd1, m_pd2, m_db, m_db_prev;
  logic m_req, m_in_ack, m_killed, m_abort;
  int   m_db_run, m_kill_run;

  task automatic model_reset();
    m_pd1 = 0; m_pd2 = 0; m_db = 0; m_db_prev = 0;
    m_req = 0; m_in_ack = 0; m_killed = 0; m_abort = 0;
    m_db_run = 0; m_kill_run = 0;
  endtask

  // Called once per active edge with the inputs present at that edge.
  task automatic model_edge(input logic pin, input logic [31:0] gpo);
    logic sync_now;
    logic rise;
    sync_now = m_pd2;
    rise     = m_db && !m_db_prev;
    if (m_req) begin
      if (gpo[1]) begin m_req = 0; m_in_ack = 1; end
    end else if (m_in_ack) begin
      if (!gpo[1]) m_in_ack = 0;
    end else if (rise) begin
      m_req = 1;
    end
    if (!m_killed) begin
      if (gpo[0]) begin
        if (m_kill_run == 0) m_abort = 0;
        m_kill_run++;
        if (m_kill_run == DELAY + 1) m_killed = 1;
      end else begin
        if (m_kill_run > 0) m_abort = 1;
        m_kill_run = 0;
      end
    end
    m_db_prev = m_db;
    if (sync_now != m_db) begin
      m_db_run++;
      if (m_db_run == DEB) begin m_db = sync_now; m_db_run = 0; end
    end else begin
      m_db_run = 0;
    end
    m_pd2 = m_pd1;
    m_pd1 = pin;
  endtask

  function automatic logic [31:0] m_gpi();
    logic [31:0] g;
    g    = '0;
    g[0] = m_req;
    g[1] = (m_kill_run > 0) && !m_killed;
    g[2] = m_abort;
    g[3] = m_db;
    g[4] = m_killed;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_gpi"},  PMU_GPI, m_gpi());
    check({tag, "_kill"}, {31'b0, KILL_POWER}, {31'b0, m_killed});
  endtask

  task automatic step(input string tag);
    @(posedge CLOCK);
    model_edge(POWER_INT, PMU_GPO);
    #1;
    check_model(tag);
  endtask

  // Reset is dropped mid-cycle so the clear must be asynchronous.
  task automatic pulse_reset(input string tag);
    #2 RESETN = 1'b0;
    #1;
    check({tag, "_async_gpi"},  PMU_GPI, 32'h0);
    check({tag, "_async_kill"}, {31'b0, KILL_POWER}, 32'h0);
    model_reset();
    #1 RESETN = 1'b1;
    $display("reset pulse %s done", tag);
  endtask

  typedef struct {
    logic       pin;
    logic [1:0] gpo;
    logic [4:0] exp_gpi;
    logic       exp_kill;
  } vec_t;

  vec_t vecs[23];

  initial begin
    RESETN = 1'b0; POWER_INT = 1'b0; PMU_GPO = '0;
    model_reset();
    #22;
    check("reset_gpi",  PMU_GPI, 32'h0);
    check("reset_kill", {31'b0, KILL_POWER}, 32'h0);
    RESETN = 1'b1;

    // Glitch of 3 cycles (entries 0-2), then a held press from entry 10.
    for (int i = 0; i < 23; i++) vecs[i] = '{pin: 1'b1, gpo: 2'b00, exp_gpi: 5'b01000, exp_kill: 1'b0};
    for (int i = 3; i < 10; i++) vecs[i].pin = 1'b0;
    for (int i = 0; i < 15; i++) vecs[i].exp_gpi = 5'b00000;
    vecs[16].exp_gpi = 5'b01001;
    vecs[17].gpo = 2'b10;
    vecs[18].gpo = 2'b10;

    for (int i = 0; i < 23; i++) begin
      POWER_INT = vecs[i].pin;
      PMU_GPO   = {30'b0, vecs[i].gpo};
      step("vec");
      check($sformatf("vec%0d_gpi", i), PMU_GPI, {27'b0, vecs[i].exp_gpi});
      check($sformatf("vec%0d_kill", i), {31'b0, KILL_POWER}, {31'b0, vecs[i].exp_kill});
      $display("vec %0d pin=%0b gpo=%b gpi=%b kill=%0b", i, vecs[i].pin, vecs[i].gpo, PMU_GPI[4:0], KILL_POWER);
    end

    // Full kill with a button press landing during the count.
    POWER_INT = 1'b0;
    repeat (8) step("release");
    check("release_db", {31'b0, PMU_GPI[3]}, 32'h0);
    PMU_GPO = 32'h1; POWER_INT = 1'b1;
    step("kill_t0");
    check("kill_cnt_start", {31'b0, PMU_GPI[1]}, 32'h1);
    for (int j = 1; j <= DELAY; j++) begin
      step("kill_run");
      if (j == 6) check("press_during_count_req", {31'b0, PMU_GPI[0]}, 32'h1);
      if (j == 7) PMU_GPO = 32'h3;
      check($sformatf("kill_timing_%0d", j), {31'b0, KILL_POWER}, {31'b0, (j == DELAY)});
    end
    check("kill_done_bit", {31'b0, PMU_GPI[4]}, 32'h1);
    check("kill_cnt_clear", {31'b0, PMU_GPI[1]}, 32'h0);
    PMU_GPO = 32'h0;
    repeat (3) step("kill_hold");
    check("kill_terminal", {31'b0, KILL_POWER}, 32'h1);
    $display("kill sequence complete");
    pulse_reset("in_kill");

    // Abort after 5 cycles, then a fresh full count.
    PMU_GPO = 32'h1;
    repeat (5) step("abort_run");
    PMU_GPO = 32'h0;
    step("abort");
    check("abort_sticky", {31'b0, PMU_GPI[2]}, 32'h1);
    check("abort_cnt", {31'b0, PMU_GPI[1]}, 32'h0);
    check("abort_nokill", {31'b0, KILL_POWER}, 32'h0);
    repeat (3) step("abort_idle");
    PMU_GPO = 32'h1;
    step("rearm");
    check("rearm_abort_clr", {31'b0, PMU_GPI[2]}, 32'h0);
    check("rearm_cnt", {31'b0, PMU_GPI[1]}, 32'h1);
    for (int j = 1; j <= DELAY; j++) begin
      step("rearm_run");
      check($sformatf("rearm_timing_%0d", j), {31'b0, KILL_POWER}, {31'b0, (j == DELAY)});
    end
    $display("abort sequence complete");
    pulse_reset("after_rearm");

    // Reset at cycle 7 of a count; a full count is needed afterwards.
    step("mid_t0");
    repeat (6) step("mid_run");
    pulse_reset("mid_count");
    for (int j = 0; j <= DELAY; j++) begin
      step("post_reset_run");
      check($sformatf("post_reset_timing_%0d", j), {31'b0, KILL_POWER}, {31'b0, (j == DELAY)});
    end
    $display("mid-count reset sequence complete");
    pulse_reset("post_reset_kill");

    // Randomized traffic against the model.
    PMU_GPO = '0; POWER_INT = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)   POWER_INT = ~POWER_INT;
      if ($urandom_range(0, 15) == 0)  PMU_GPO[0] = ~PMU_GPO[0];
      if ($urandom_range(0, 3) == 0)   PMU_GPO[1] = ~PMU_GPO[1];
      if ($urandom_range(0, 31) == 0)  PMU_GPO[31:2] = 30'($urandom);
      if ($urandom_range(0, 299) == 0) pulse_reset("random");
      step("random");
    end
    $display("random phase complete");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
